board_draw_sequencer: RTL and testbench
=======================================

Name: board_draw_sequencer

Overview:
- Frame-level controller for the board renderer.
- On a start pulse it walks every board cell in row-major order and reads the cell's 8-bit code from board RAM.
- For each cell it sweeps the full 16x12 pixel tile, driving plot/x/y/colour to the VGA adapter: shape pixels get the cell colour, all other tile pixels are black.
- Sits between the board storage (read port) and the VGA adapter; replaces the free-running per-cell draw counters with one deterministic, sequenced pass.

Parameters:
- COLS, 10, board columns (1..16).
- ROWS, 10, board rows (1..16).
- TILE_W, 16, tile width in pixels (power of two, fixed pixel counter width 4).
- TILE_H, 12, tile height in pixels (<=16).

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE completes.
- done  out  1  one-cycle pulse when the final pixel of the frame has been plotted.
- mem_addr  out  8  board RAM address: [7:4] row, [3:0] col.
- mem_rd  out  1  read strobe; data is valid on mem_data exactly one cycle later.
- mem_data  in  8  cell code from board RAM.
- plot  out  1  pixel write enable to the VGA adapter.
- x  out  8  pixel x (0..159).
- y  out  7  pixel y (0..119).
- colour  out  3  pixel colour.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - busy, done, plot, mem_rd = 0.
  - mem_addr, x, y, colour = 0; row/col/px/py counters = 0.
  - Reset mid-frame aborts immediately with no further plots.
- States: IDLE -> READ -> LATCH -> DRAW -> (READ | DONE) -> IDLE.
- IDLE: start=1 -> READ with row=col=0; busy=1 from next cycle. start while busy is ignored (not queued).
- READ (1 cycle):
  - mem_rd=1.
  - mem_addr={row,col} is registered and held stable for the whole cell.
- LATCH (1 cycle): cell_reg <= mem_data; px=py=0.
- DRAW (TILE_W*TILE_H = 192 cycles):
  - plot=1 every cycle; outputs are registered and plot is coincident with x/y/colour.
  - x = col*16 + px, computed in 8 bits.
  - y = row*12 + py, computed in 7 bits as (row<<4)-(row<<2)+py.
  - Scan order: px increments 0..15; on px=15, px wraps to 0 and py increments; tile ends at px=15, py=11.
- Colour decode on cell_reg (exact match). A pixel outside the shape gets 3'b000.
  - 8'b1000_0000 wall: all pixels 3'b011.
  - 8'b0100_0000 tank1: px 4..11 and py 2..9 -> 3'b101.
  - 8'b0010_0000 tank2: same box -> 3'b001.
  - 8'b0001_0100 left/right projectile: py 5..6, all px -> 3'b110.
  - 8'b0001_1000 up/down projectile: px 7..8, all py -> 3'b110.
  - Any other code (including 0): whole tile 3'b000, i.e. cleared.
- End of tile:
  - col<COLS-1: col+1, go to READ.
  - Else if row<ROWS-1: col=0, row+1, go to READ.
  - Else go to DONE.
- DONE (1 cycle): done=1, plot=0, busy=0 in the same cycle; return to IDLE. start in this cycle is ignored.
- Latency:
  - start to first plot: 3 cycles (READ, LATCH, then first DRAW).
  - Per cell: 194 cycles. Full 10x10 frame: 19400 cycles, then 1 DONE cycle.
- plot=0 in every state except DRAW.
- mem_rd is high only in READ.
- mem_data is sampled only in LATCH; changes at other times have no effect on the current tile.

Test Plan:
- Reset then start with RAM all zero -> 19200 plots, all colour 0; first plot (x=0,y=0) 3 cycles after start; last plot (159,119); done pulses at cycle 19401 after start, busy low with it.
- Cell (row 2, col 3) = 8'h80 -> its 192 plots cover x 48..63, y 24..35, all colour 3'b011; mem_addr=8'h23 during that cell.
- Cell (0,0) = 8'h40 -> exactly 64 plots of 3'b101 at x 4..11, y 2..9; remaining 128 tile plots 0. Cell 8'h20 -> same box, 3'b001.
- Cell (1,1) = 8'h14 -> 32 plots of 3'b110 at y 17..18; cell 8'h18 -> 24 plots of 3'b110 at x 23..24 (if placed at (1,1)).
- start pulsed mid-frame and in the DONE cycle -> ignored, frame length unchanged; start in IDLE afterwards launches a new frame.
- resetn low during DRAW of cell 5 -> plot, busy, mem_rd drop asynchronously; no done; next start begins again at address 8'h00.

Source files
------------

// File: rtl/board_draw_sequencer.sv
// -----------------------------------------------------------------------------
// board_draw_sequencer
//
// Frame-level controller for the board renderer. A start pulse launches one
// deterministic pass over the board in row-major order. For each cell it
// reads the 8-bit cell code from board RAM, latches it, and then sweeps the
// full 16x12 pixel tile. Shape pixels get the cell colour and all other tile
// pixels are drawn black.
//
// Ports
//   clock     in   system clock
//   resetn    in   asynchronous active-low reset
//   start     in   single-cycle frame request (only honoured in IDLE)
//   busy      out  frame in progress (drops in the DONE cycle)
//   done      out  one-cycle pulse after the final pixel of the frame
//   mem_addr  out  board RAM address {row[3:0], col[3:0]}, held for the whole cell
//   mem_rd    out  RAM read strobe; data is expected on mem_data one cycle later
//   mem_data  in   cell code from board RAM
//   plot      out  pixel write enable to the VGA adapter
//   x         out  pixel x (0..159)
//   y         out  pixel y (0..119)
//   colour    out  pixel colour
// -----------------------------------------------------------------------------
module board_draw_sequencer #(
    parameter int COLS   = 10,
    parameter int ROWS   = 10,
    parameter int TILE_W = 16,
    parameter int TILE_H = 12
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] PX_LAST  = 4'(TILE_W - 1);
    localparam logic [3:0] PY_LAST  = 4'(TILE_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_DRAW,
        S_DONE
    } state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_row, w_row_next;
    logic [3:0] r_col, w_col_next;
    logic [3:0] r_px, w_px_next;
    logic [3:0] r_py, w_py_next;
    logic [7:0] r_cell, w_cell_next;
    logic [7:0] r_addr, w_addr_next;
    logic       r_rd, w_rd_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;
    logic       r_plot, w_plot_next;
    logic [7:0] r_x, w_x_next;
    logic [6:0] r_y, w_y_next;
    logic [2:0] r_colour, w_colour_next;

    logic       w_pix_update;
    logic       w_tile_end;
    logic [6:0] w_row7;

    // Shape lookup: exact code match, anything unknown clears the tile.
    function automatic logic [2:0] shape_colour(input logic [7:0] code,
                                                input logic [3:0] px,
                                                input logic [3:0] py);
        logic box;
        box = (px >= 4'd4) && (px <= 4'd11) && (py >= 4'd2) && (py <= 4'd9);
        case (code)
            8'b1000_0000: shape_colour = 3'b011;
            8'b0100_0000: shape_colour = box ? 3'b101 : 3'b000;
            8'b0010_0000: shape_colour = box ? 3'b001 : 3'b000;
            8'b0001_0100: shape_colour = ((py == 4'd5) || (py == 4'd6)) ? 3'b110 : 3'b000;
            8'b0001_1000: shape_colour = ((px == 4'd7) || (px == 4'd8)) ? 3'b110 : 3'b000;
            default:      shape_colour = 3'b000;
        endcase
    endfunction

    assign w_tile_end = (r_px == PX_LAST) && (r_py == PY_LAST);
    assign w_row7     = {3'b000, r_row};

    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row;
        w_col_next    = r_col;
        w_px_next     = r_px;
        w_py_next     = r_py;
        w_cell_next   = r_cell;
        w_addr_next   = r_addr;
        w_rd_next     = 1'b0;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_plot_next   = 1'b0;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_pix_update  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_READ;
                    w_busy_next  = 1'b1;
                    w_row_next   = 4'd0;
                    w_col_next   = 4'd0;
                    w_addr_next  = 8'h00;
                    w_rd_next    = 1'b1;
                end
            end
            S_READ: begin
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                // First pixel is presented straight from the RAM data so that
                // plotting begins on the first DRAW cycle.
                w_state_next = S_DRAW;
                w_cell_next  = mem_data;
                w_px_next    = 4'd0;
                w_py_next    = 4'd0;
                w_pix_update = 1'b1;
            end
            S_DRAW: begin
                // r_px/r_py name the pixel currently on the outputs.
                if (w_tile_end) begin
                    if ((r_col == COL_LAST) && (r_row == ROW_LAST)) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_state_next = S_READ;
                        w_rd_next    = 1'b1;
                        if (r_col == COL_LAST) begin
                            w_col_next = 4'd0;
                            w_row_next = r_row + 4'd1;
                        end else begin
                            w_col_next = r_col + 4'd1;
                        end
                        w_addr_next = {w_row_next, w_col_next};
                    end
                end else begin
                    if (r_px == PX_LAST) begin
                        w_px_next = 4'd0;
                        w_py_next = r_py + 4'd1;
                    end else begin
                        w_px_next = r_px + 4'd1;
                    end
                    w_pix_update = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_pix_update) begin
            w_plot_next   = 1'b1;
            w_x_next      = {r_col, 4'b0000} + {4'b0000, w_px_next};
            // row*12 as (row<<4)-(row<<2); wrap-around in 7 bits is harmless.
            w_y_next      = (w_row7 << 4) - (w_row7 << 2) + {3'b000, w_py_next};
            w_colour_next = shape_colour(w_cell_next, w_px_next, w_py_next);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_row    <= 4'd0;
            r_col    <= 4'd0;
            r_px     <= 4'd0;
            r_py     <= 4'd0;
            r_cell   <= 8'h00;
            r_addr   <= 8'h00;
            r_rd     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_x      <= 8'h00;
            r_y      <= 7'h00;
            r_colour <= 3'b000;
        end else begin
            r_state  <= w_state_next;
            r_row    <= w_row_next;
            r_col    <= w_col_next;
            r_px     <= w_px_next;
            r_py     <= w_py_next;
            r_cell   <= w_cell_next;
            r_addr   <= w_addr_next;
            r_rd     <= w_rd_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_plot   <= w_plot_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_addr = r_addr;
    assign mem_rd   = r_rd;
    assign plot     = r_plot;
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = r_colour;

endmodule

// File: tb/tb_board_draw_sequencer.sv
module tb_board_draw_sequencer;

    localparam int COLS  = 10;
    localparam int ROWS  = 10;
    localparam int NPIX  = COLS * ROWS * 192;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, mem_rd, plot;
    logic [7:0] mem_addr, x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [7:0] mem_data = 8'h00;

    board_draw_sequencer #(.COLS(COLS), .ROWS(ROWS), .TILE_W(16), .TILE_H(12)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour)
    );

    always #10 clock = ~clock;

    // Board RAM: one-cycle read latency; junk on the bus when not reading so
    // that sampling outside LATCH would be visible.
    logic [7:0] ram [256];
    always @(posedge clock) mem_data <= mem_rd ? ram[mem_addr] : 8'($urandom);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model: the frame as a list of plots ----------
    typedef struct {
        logic [7:0] addr;
        logic [7:0] px_x;
        logic [6:0] px_y;
        logic [2:0] c;
    } pix_t;
    pix_t exp_q[$];

    function automatic logic [2:0] model_colour(input logic [7:0] code, input int px, input int py);
        bit in_box;
        in_box = (px inside {[4:11]}) && (py inside {[2:9]});
        if (code == 8'h80) return 3'b011;
        if (code == 8'h40 && in_box) return 3'b101;
        if (code == 8'h20 && in_box) return 3'b001;
        if (code == 8'h14 && (py == 5 || py == 6)) return 3'b110;
        if (code == 8'h18 && (px == 7 || px == 8)) return 3'b110;
        return 3'b000;
    endfunction

    task automatic build_expected();
        pix_t p;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int py = 0; py < 12; py++)
                    for (int px = 0; px < 16; px++) begin
                        p.addr = 8'(r * 16 + c);
                        p.px_x = 8'(c * 16 + px);
                        p.px_y = 7'(r * 12 + py);
                        p.c    = model_colour(ram[r * 16 + c], px, py);
                        exp_q.push_back(p);
                    end
    endtask

    // ---------------- monitor --------------------------------------------------
    bit    mon_en = 1'b0;
    int    mon_errs, mon_plots, last_x, last_y;
    string first_err;
    int    lit_cnt [256];
    int    lit_col [256];
    int    lit_mix [256];
    int    xmin [256], xmax [256], ymin [256], ymax [256];

    always @(negedge clock) begin : monitor
        pix_t e;
        int   t;
        if (mon_en && plot) begin
            mon_plots++;
            last_x = int'(x);
            last_y = int'(y);
            if (mem_rd) begin
                if (mon_errs == 0) first_err = "mem_rd high during plot";
                mon_errs++;
            end
            if (exp_q.size() == 0) begin
                if (mon_errs == 0) first_err = $sformatf("unexpected plot x=%0d y=%0d", x, y);
                mon_errs++;
            end else begin
                e = exp_q.pop_front();
                if (x != e.px_x || y != e.px_y || colour != e.c || mem_addr != e.addr) begin
                    if (mon_errs == 0)
                        first_err = $sformatf("plot #%0d got x=%0d y=%0d c=%0d a=%h want x=%0d y=%0d c=%0d a=%h",
                                              mon_plots, x, y, colour, mem_addr, e.px_x, e.px_y, e.c, e.addr);
                    mon_errs++;
                end
            end
            t = (int'(y) / 12) * 16 + int'(x) / 16;
            if (colour != 3'b000 && t < 256) begin
                if (lit_cnt[t] == 0) begin
                    lit_col[t] = int'(colour);
                    xmin[t] = int'(x); xmax[t] = int'(x);
                    ymin[t] = int'(y); ymax[t] = int'(y);
                end else begin
                    if (int'(colour) != lit_col[t]) lit_mix[t] = 1;
                    if (int'(x) < xmin[t]) xmin[t] = int'(x);
                    if (int'(x) > xmax[t]) xmax[t] = int'(x);
                    if (int'(y) < ymin[t]) ymin[t] = int'(y);
                    if (int'(y) > ymax[t]) ymax[t] = int'(y);
                end
                lit_cnt[t]++;
            end
        end
    end

    // ---------------- one full frame ------------------------------------------
    task automatic run_frame(input string tag, input int mid_start, input bit start_in_done);
        int n, first_plot, done_cyc, busy_at_done;
        for (int i = 0; i < 256; i++) begin
            lit_cnt[i] = 0; lit_col[i] = 0; lit_mix[i] = 0;
        end
        mon_errs = 0; mon_plots = 0; last_x = -1; last_y = -1; first_err = "";
        build_expected();
        first_plot = -1; done_cyc = -1; busy_at_done = -1;
        @(negedge clock);
        mon_en = 1'b1;
        start  = 1'b1;
        @(negedge clock);
        n = 1;
        check({tag, " busy_cycle1"}, int'(busy), 1);
        check({tag, " rd_cycle1"}, int'({mem_rd, mem_addr}), 9'h100);
        while (1) begin
            start = 1'b0;
            if (plot && first_plot < 0) first_plot = n;
            if (done) begin
                done_cyc = n;
                busy_at_done = int'({busy, plot});
                if (start_in_done) start = 1'b1;
                break;
            end
            if (n == mid_start) start = 1'b1;
            if (n >= 25000) break;
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        start  = 1'b0;
        mon_en = 1'b0;
        check({tag, " first_plot_cycle"}, first_plot, 3);
        check({tag, " done_cycle"}, done_cyc, NPIX + COLS * ROWS * 2 + 1);
        check({tag, " busy_plot_at_done"}, busy_at_done, 0);
        check({tag, " plot_count"}, mon_plots, NPIX);
        check({tag, " last_xy"}, last_x * 256 + last_y, 159 * 256 + 119);
        if (mon_errs != 0) $display("FAIL %s first stream error: %s", tag, first_err);
        check({tag, " stream_errors"}, mon_errs, 0);
        check({tag, " missing_plots"}, exp_q.size(), 0);
        repeat (3) @(negedge clock);
        check({tag, " idle_after_done"}, int'({busy, plot, done}), 0);
    endtask

    // ---------------- table of single-cell shape checks ------------------------
    typedef struct {
        int         row;
        int         col;
        logic [7:0] code;
        int         lit;
        int         c;
        int         xlo, xhi, ylo, yhi;
    } vec_t;
    vec_t vt [7];

    logic [7:0] pal [6];

    initial begin
        int t, n, cnt_plot, cnt_done;

        vt[0] = '{2, 3, 8'h80, 192, 3, 48, 63, 24, 35};
        vt[1] = '{0, 0, 8'h40,  64, 5,  4, 11,  2,  9};
        vt[2] = '{0, 1, 8'h20,  64, 1, 20, 27,  2,  9};
        vt[3] = '{1, 1, 8'h14,  32, 6, 16, 31, 17, 18};
        vt[4] = '{1, 2, 8'h18,  24, 6, 39, 40, 12, 23};
        vt[5] = '{3, 3, 8'h00,   0, 0,  0,  0,  0,  0};
        vt[6] = '{4, 4, 8'h81,   0, 0,  0,  0,  0,  0};
        pal = '{8'h80, 8'h40, 8'h20, 8'h14, 8'h18, 8'h00};

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // Reset state
        #5;
        check("reset_outputs", int'({busy, done, mem_rd, plot, mem_addr, x, y, colour}), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_outputs", int'({busy, done, mem_rd, plot}), 0);

        // Frame 1: empty board
        run_frame("blank", -1, 1'b0);
        t = 0;
        for (int i = 0; i < 256; i++) t += lit_cnt[i];
        check("blank lit_pixels", t, 0);

        // Frame 2: random background plus the table cells
        for (int i = 0; i < 256; i++)
            ram[i] = ($urandom_range(0, 6) == 6) ? 8'($urandom) : pal[$urandom_range(0, 5)];
        for (int v = 0; v < 7; v++) ram[vt[v].row * 16 + vt[v].col] = vt[v].code;
        run_frame("table", -1, 1'b0);
        for (int v = 0; v < 7; v++) begin
            t = vt[v].row * 16 + vt[v].col;
            check($sformatf("cell%0d%0d_%h lit", vt[v].row, vt[v].col, vt[v].code), lit_cnt[t], vt[v].lit);
            if (vt[v].lit > 0) begin
                check($sformatf("cell%0d%0d_%h colour", vt[v].row, vt[v].col, vt[v].code),
                      lit_col[t] + 8 * lit_mix[t], vt[v].c);
                check($sformatf("cell%0d%0d_%h bbox", vt[v].row, vt[v].col, vt[v].code),
                      (xmin[t] << 24) | (xmax[t] << 16) | (ymin[t] << 8) | ymax[t],
                      (vt[v].xlo << 24) | (vt[v].xhi << 16) | (vt[v].ylo << 8) | vt[v].yhi);
            end
        end

        // Frame 3: fully random board, start pulsed mid-frame and in DONE
        for (int i = 0; i < 256; i++)
            ram[i] = ($urandom_range(0, 4) == 4) ? 8'($urandom) : pal[$urandom_range(0, 5)];
        run_frame("random_ignored_starts", 5000, 1'b1);

        // Frame 4: asynchronous reset during DRAW of cell 5
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (n < 5 * 194 + 3 + 40) begin
            @(negedge clock);
            n++;
        end
        check("pre_reset_drawing", int'({busy, plot, mem_addr}), 10'h305);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({busy, done, mem_rd, plot, mem_addr}), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        cnt_plot = 0;
        cnt_done = 0;
        repeat (300) begin
            @(negedge clock);
            cnt_plot += int'(plot);
            cnt_done += int'(done) + int'(busy);
        end
        check("post_reset_silent", cnt_plot * 1000 + cnt_done, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart_addr", int'({mem_rd, mem_addr}), 9'h100);
        repeat (2) @(negedge clock);
        check("restart_first_plot", int'({plot, x, y}), 16'h8000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
